// File: rtl/eq_coeff_bank_ctrl_if.sv
// Bus bundle for eq_coeff_bank_ctrl: equalizer read port, monitored equalizer
// output handshake and the host configuration port.
// Optional feature macro: EQ_COEFF_READBACK_EN (adds the shadow readback signals).
// master = host/equalizer side, slave = coefficient bank controller.
interface eq_coeff_bank_ctrl_if #(
    parameter int NR_CHANNELS    = 3,
    parameter int NR_EQ_BANDS    = 8,
    parameter int EQ_COEFF_WIDTH = 32
);
    localparam int NR_EQ_COEFF   = NR_CHANNELS * NR_EQ_BANDS * 5;
    localparam int ADDR_WIDTH    = $clog2(NR_EQ_COEFF);
    localparam int CHANNEL_WIDTH = $clog2(NR_CHANNELS);

    // equalizer coefficient read port
    logic [ADDR_WIDTH-1:0]     eq_coeff_addr;
    logic [EQ_COEFF_WIDTH-1:0] eq_coeff;
    // monitored equalizer output handshake
    logic [CHANNEL_WIDTH-1:0]  m_eq_ch;
    logic                      m_eq_dv;
    logic                      m_eq_dr;
    // host configuration port
    logic [ADDR_WIDTH-1:0]     cfg_wr_addr;
    logic [EQ_COEFF_WIDTH-1:0] cfg_wr_d;
    logic                      cfg_wr_dv;
    logic                      cfg_wr_dr;
    logic                      cfg_commit;
    logic                      cfg_busy;
    logic                      cfg_done;
    logic                      cfg_addr_err;
    logic                      active_bank;
`ifdef EQ_COEFF_READBACK_EN
    logic [ADDR_WIDTH-1:0]     cfg_rd_addr;
    logic                      cfg_rd_en;
    logic [EQ_COEFF_WIDTH-1:0] cfg_rd_d;
    logic                      cfg_rd_dv;

    modport master (
        output eq_coeff_addr, m_eq_ch, m_eq_dv, m_eq_dr,
        output cfg_wr_addr, cfg_wr_d, cfg_wr_dv, cfg_commit, cfg_rd_addr, cfg_rd_en,
        input  eq_coeff, cfg_wr_dr, cfg_busy, cfg_done, cfg_addr_err, active_bank,
        input  cfg_rd_d, cfg_rd_dv
    );
    modport slave (
        input  eq_coeff_addr, m_eq_ch, m_eq_dv, m_eq_dr,
        input  cfg_wr_addr, cfg_wr_d, cfg_wr_dv, cfg_commit, cfg_rd_addr, cfg_rd_en,
        output eq_coeff, cfg_wr_dr, cfg_busy, cfg_done, cfg_addr_err, active_bank,
        output cfg_rd_d, cfg_rd_dv
    );
`else
    modport master (
        output eq_coeff_addr, m_eq_ch, m_eq_dv, m_eq_dr,
        output cfg_wr_addr, cfg_wr_d, cfg_wr_dv, cfg_commit,
        input  eq_coeff, cfg_wr_dr, cfg_busy, cfg_done, cfg_addr_err, active_bank
    );
    modport slave (
        input  eq_coeff_addr, m_eq_ch, m_eq_dv, m_eq_dr,
        input  cfg_wr_addr, cfg_wr_d, cfg_wr_dv, cfg_commit,
        output eq_coeff, cfg_wr_dr, cfg_busy, cfg_done, cfg_addr_err, active_bank
    );
`endif
endinterface

// File: rtl/eq_coeff_bank_ctrl.sv
// Double-buffered biquad coefficient store with frame-aligned bank swap.
// The equalizer always reads the active bank; the host fills the shadow bank,
// and a commit swaps the banks on the next frame boundary (last channel's
// output accepted), then mirrors the new active bank back into the shadow.
// Optional feature macro: EQ_COEFF_READBACK_EN (host readback of the shadow bank).
module eq_coeff_bank_ctrl #(
    parameter int NR_CHANNELS    = 3,
    parameter int NR_EQ_BANDS    = 8,
    parameter int EQ_COEFF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    eq_coeff_bank_ctrl_if.slave   bus
);
    localparam int NR_EQ_COEFF   = NR_CHANNELS * NR_EQ_BANDS * 5;
    localparam int ADDR_WIDTH    = $clog2(NR_EQ_COEFF);
    localparam int CHANNEL_WIDTH = $clog2(NR_CHANNELS);
    // a0 = 1.0 in the 4-integer-bit signed format
    localparam logic [EQ_COEFF_WIDTH-1:0] UNITY_A0 = EQ_COEFF_WIDTH'(1) << (EQ_COEFF_WIDTH - 4);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_PENDING,
        ST_SWAP,
        ST_COPY
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    active_q, active_d;
    logic                    done_q, done_d;
    logic                    addr_err_q, addr_err_d;
    logic                    eq_ok_q;
    logic                    eq_sel_q;
    logic                    aux_sel_q;

    logic                    cnt_last;
    logic                    boundary;
    logic                    wr_accept;
    logic                    wr_in_range;
    logic                    eq_addr_ok;
    logic                    shadow_sel;
    logic [ADDR_WIDTH-1:0]   aux_addr;
    logic                    aux_sel;
    logic                    aux_addr_ok;
    logic [EQ_COEFF_WIDTH-1:0] aux_data;
    logic [EQ_COEFF_WIDTH-1:0] unity_word;

    logic [1:0]                       wr_en;
    logic [1:0][ADDR_WIDTH-1:0]       wr_addr;
    logic [1:0][EQ_COEFF_WIDTH-1:0]   wr_data;
    logic [1:0][EQ_COEFF_WIDTH-1:0]   eq_rd;
    logic [1:0][EQ_COEFF_WIDTH-1:0]   aux_rd;

    assign cnt_last    = (cnt_q == ADDR_WIDTH'(NR_EQ_COEFF - 1));
    assign boundary    = bus.m_eq_dv && bus.m_eq_dr &&
                         (bus.m_eq_ch == CHANNEL_WIDTH'(NR_CHANNELS - 1));
    assign wr_accept   = (state_q == ST_IDLE) && bus.cfg_wr_dv;
    assign wr_in_range = (int'(bus.cfg_wr_addr) < NR_EQ_COEFF);
    assign eq_addr_ok  = (int'(bus.eq_coeff_addr) < NR_EQ_COEFF);
    assign aux_addr_ok = (int'(aux_addr) < NR_EQ_COEFF);
    assign shadow_sel  = ~active_q;
    // coefficient index k = addr mod 5; k == 0 is a0
    assign unity_word  = ((int'(cnt_q) % 5) == 0) ? UNITY_A0 : '0;

    // FSM next state plus bank select, done pulse and sticky address error
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        done_d     = 1'b0;
        addr_err_d = addr_err_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (wr_accept && !wr_in_range) begin
                    addr_err_d = 1'b1;
                end
                // the write of this cycle is taken first, then the commit clears the flag
                if (bus.cfg_commit) begin
                    addr_err_d = 1'b0;
                    state_d    = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (boundary) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                active_d = ~active_q;
                cnt_d    = '0;
                state_d  = ST_COPY;
            end
            ST_COPY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // FSM and control registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            eq_ok_q    <= 1'b0;
            eq_sel_q   <= 1'b0;
            aux_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            done_q     <= done_d;
            addr_err_q <= addr_err_d;
            eq_ok_q    <= eq_addr_ok;
            eq_sel_q   <= active_q;
            aux_sel_q  <= aux_sel;
        end
    end

    // Auxiliary read port: copy source during SWAP/COPY, shadow readback in IDLE.
    // SWAP prefetches word 0 so COPY retires one word per cycle.
    always_comb begin
        aux_addr = cnt_q + 1'b1;
        aux_sel  = active_q;
        if (state_q == ST_SWAP) begin
            aux_addr = '0;
            aux_sel  = ~active_q;
        end
`ifdef EQ_COEFF_READBACK_EN
        else if (state_q == ST_IDLE) begin
            aux_addr = bus.cfg_rd_addr;
            aux_sel  = ~active_q;
        end
`endif
    end

    assign aux_data = aux_rd[aux_sel_q];

    // Per-bank write port: INIT fills both, IDLE host writes and COPY target the shadow
    always_comb begin
        wr_en   = 2'b00;
        wr_addr = {2{cnt_q}};
        wr_data = {2{unity_word}};
        case (state_q)
            ST_INIT: begin
                wr_en = 2'b11;
            end
            ST_IDLE: begin
                if (wr_accept && wr_in_range) begin
                    wr_en[shadow_sel]   = 1'b1;
                    wr_addr[shadow_sel] = bus.cfg_wr_addr;
                    wr_data[shadow_sel] = bus.cfg_wr_d;
                end
            end
            ST_COPY: begin
                wr_en[shadow_sel]   = 1'b1;
                wr_data[shadow_sel] = aux_data;
            end
            default: begin
                wr_en = 2'b00;
            end
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [EQ_COEFF_WIDTH-1:0] mem [NR_EQ_COEFF];
        logic [EQ_COEFF_WIDTH-1:0] eq_rd_q;
        logic [EQ_COEFF_WIDTH-1:0] aux_rd_q;

        // One write port and two registered read ports per bank
        always_ff @(posedge clk) begin
            if (wr_en[gi]) begin
                mem[wr_addr[gi]] <= wr_data[gi];
            end
            if (eq_addr_ok) begin
                eq_rd_q <= mem[bus.eq_coeff_addr];
            end
            if (aux_addr_ok) begin
                aux_rd_q <= mem[aux_addr];
            end
        end

        assign eq_rd[gi]  = eq_rd_q;
        assign aux_rd[gi] = aux_rd_q;
    end

    assign bus.eq_coeff     = eq_ok_q ? eq_rd[eq_sel_q] : '0;
    assign bus.cfg_wr_dr    = (state_q == ST_IDLE);
    assign bus.cfg_busy     = (state_q != ST_IDLE);
    assign bus.cfg_done     = done_q;
    assign bus.cfg_addr_err = addr_err_q;
    assign bus.active_bank  = active_q;

`ifdef EQ_COEFF_READBACK_EN
    logic rd_dv_q;
    logic rd_ok_q;

    // Shadow readback strobe, honoured in IDLE only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_dv_q <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            rd_dv_q <= bus.cfg_rd_en && (state_q == ST_IDLE);
            rd_ok_q <= bus.cfg_rd_en && (state_q == ST_IDLE) &&
                       (int'(bus.cfg_rd_addr) < NR_EQ_COEFF);
        end
    end

    assign bus.cfg_rd_dv = rd_dv_q;
    assign bus.cfg_rd_d  = rd_ok_q ? aux_data : '0;
`endif

endmodule

// File: tb/tb_eq_coeff_bank_ctrl.sv
// Scoreboard bench for eq_coeff_bank_ctrl: the stimulus process advances an
// abstract model (logical active/shadow coefficient arrays plus timing of the
// commit -> boundary -> swap -> mirror sequence) and queues the expected
// outputs; a monitor pops and compares once per clock.
module tb_eq_coeff_bank_ctrl;
    localparam int N  = 120;
    localparam int W  = 32;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eq_coeff_bank_ctrl_if #(.NR_CHANNELS(3), .NR_EQ_BANDS(8), .EQ_COEFF_WIDTH(W)) bus ();

    eq_coeff_bank_ctrl #(.NR_CHANNELS(3), .NR_EQ_BANDS(8), .EQ_COEFF_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int           e;
        bit           chk_eq;
        logic [W-1:0] eq;
        bit           ab;
        bit           busy;
        bit           wr_dr;
        bit           done;
        bit           err;
        bit           rd_dv;
        logic [W-1:0] rd_d;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_fail = 0;

    // abstract reference state
    logic [W-1:0] act [N];
    logic [W-1:0] shd [N];
    bit ab, err, pending, in_reset;
    int edge_n = 0, idle_from = 0, init_end = 0, swap_edge = -1, done_edge = -1;

    task automatic chk(input string name, input int e, input logic [W-1:0] got, input logic [W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %h expected %h", name, e, got, want);
        end
    endtask

    // advance the model by one clock edge with the inputs currently driven
    task automatic step();
        exp_t x;
        bit   idle_now, b_evt;
        x = '{e: edge_n, chk_eq: 1'b0, eq: '0, ab: 1'b0, busy: 1'b1, wr_dr: 1'b0,
              done: 1'b0, err: 1'b0, rd_dv: 1'b0, rd_d: '0};
        if (!rst_n) begin
            x.chk_eq = 1'b1;
            ab = 1'b0; err = 1'b0; pending = 1'b0;
            swap_edge = -1; done_edge = -1;
            init_end = edge_n + N + 1; idle_from = init_end;
            for (int i = 0; i < N; i++) begin
                act[i] = (i % 5 == 0) ? 32'h1000_0000 : 32'h0;
                shd[i] = act[i];
            end
            if (!in_reset) $display("edge %0d: reset", edge_n);
            in_reset = 1'b1;
        end else begin
            in_reset = 1'b0;
            idle_now = !pending && (edge_n >= idle_from);
            b_evt = bus.m_eq_dv && bus.m_eq_dr && (bus.m_eq_ch == 2'd2);
            x.chk_eq = (edge_n >= init_end);
            x.eq = (bus.eq_coeff_addr < N) ? act[bus.eq_coeff_addr] : '0;
`ifdef EQ_COEFF_READBACK_EN
            if (bus.cfg_rd_en && idle_now) begin
                x.rd_dv = 1'b1;
                x.rd_d  = (bus.cfg_rd_addr < N) ? shd[bus.cfg_rd_addr] : '0;
            end
`endif
            if (idle_now && bus.cfg_wr_dv) begin
                if (bus.cfg_wr_addr < N) shd[bus.cfg_wr_addr] = bus.cfg_wr_d;
                else err = 1'b1;
                $display("edge %0d: write addr %0d data %h", edge_n, bus.cfg_wr_addr, bus.cfg_wr_d);
            end
            if (idle_now && bus.cfg_commit) begin
                err = 1'b0;
                pending = 1'b1;
                $display("edge %0d: commit", edge_n);
            end else if (pending && b_evt) begin
                pending = 1'b0;
                swap_edge = edge_n + 1;
                done_edge = edge_n + N + 1;
                idle_from = edge_n + N + 2;
                $display("edge %0d: frame boundary, swap scheduled", edge_n);
            end
            if (edge_n == swap_edge) begin
                ab = ~ab;
                act = shd;
            end
            x.done  = (edge_n == done_edge);
            x.ab    = ab;
            x.err   = err;
            x.wr_dr = !pending && (edge_n + 1 >= idle_from);
            x.busy  = !x.wr_dr;
        end
        exp_q.push_back(x);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        bus.eq_coeff_addr = AW'($urandom_range(0, 127));
        bus.m_eq_ch = 2'd0; bus.m_eq_dv = 1'b0; bus.m_eq_dr = 1'b0;
        bus.cfg_wr_addr = '0; bus.cfg_wr_d = '0; bus.cfg_wr_dv = 1'b0; bus.cfg_commit = 1'b0;
`ifdef EQ_COEFF_READBACK_EN
        bus.cfg_rd_addr = AW'($urandom_range(0, 127));
        bus.cfg_rd_en = 1'b0;
`endif
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            quiet_inputs();
            step();
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        quiet_inputs();
        bus.cfg_wr_addr = a; bus.cfg_wr_d = d; bus.cfg_wr_dv = 1'b1;
        step();
    endtask

    task automatic do_commit();
        quiet_inputs();
        bus.cfg_commit = 1'b1;
        step();
    endtask

    task automatic do_out(input logic [1:0] ch);
        quiet_inputs();
        bus.m_eq_ch = ch; bus.m_eq_dv = 1'b1; bus.m_eq_dr = 1'b1;
        step();
    endtask

    task automatic rand_cycle();
        quiet_inputs();
        bus.cfg_wr_dv   = ($urandom % 4 == 0);
        bus.cfg_wr_addr = ($urandom % 16 == 0) ? AW'($urandom_range(120, 127)) : AW'($urandom_range(0, 119));
        bus.cfg_wr_d    = $urandom;
        bus.cfg_commit  = ($urandom % 50 == 0);
        bus.m_eq_dv     = $urandom_range(0, 1);
        bus.m_eq_dr     = $urandom_range(0, 1);
        bus.m_eq_ch     = 2'($urandom_range(0, 3));
`ifdef EQ_COEFF_READBACK_EN
        bus.cfg_rd_en   = ($urandom % 3 == 0);
`endif
        step();
    endtask

    // monitor: one expected record per clock edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                if (x.chk_eq) chk("eq_coeff", x.e, bus.eq_coeff, x.eq);
                chk("active_bank", x.e, W'(bus.active_bank), W'(x.ab));
                chk("cfg_busy", x.e, W'(bus.cfg_busy), W'(x.busy));
                chk("cfg_wr_dr", x.e, W'(bus.cfg_wr_dr), W'(x.wr_dr));
                chk("cfg_done", x.e, W'(bus.cfg_done), W'(x.done));
                chk("cfg_addr_err", x.e, W'(bus.cfg_addr_err), W'(x.err));
`ifdef EQ_COEFF_READBACK_EN
                chk("cfg_rd_dv", x.e, W'(bus.cfg_rd_dv), W'(x.rd_dv));
                if (x.rd_dv) chk("cfg_rd_d", x.e, bus.cfg_rd_d, x.rd_d);
`endif
            end
        end
    end

    // stimulus
    initial begin
        rst_n = 1'b0;
        quiet_inputs();
        for (int i = 0; i < 3; i++) begin
            quiet_inputs();
            step();
        end
        rst_n = 1'b1;
        idle_cycles(N + 5);

        // new a0 = 1.5 held back while no frame boundary arrives
        do_write(7'd0, 32'h1800_0000);
        do_commit();
        for (int i = 0; i < 100; i++) begin
            quiet_inputs();
            if (i % 2 == 0) bus.eq_coeff_addr = 7'd0;
            step();
        end
        do_out(2'd2);
        idle_cycles(N + 10);

        // non-final channel does not swap; second commit while pending is ignored
        do_write(7'd5, 32'hF800_0000);
        do_commit();
        do_out(2'd1);
        do_out(2'd0);
        do_commit();
        idle_cycles(4);
        do_out(2'd2);
        idle_cycles(N + 10);

        // out-of-range write flags an error, next commit clears it
        do_write(7'd120, 32'h1234_5678);
        idle_cycles(3);
        do_commit();
        idle_cycles(2);
        do_out(2'd2);
        idle_cycles(N + 10);

        for (int i = 0; i < 3000; i++) rand_cycle();
        idle_cycles(N + 10);

        // reset in the middle of the mirror copy
        do_write(7'd10, 32'h0800_0000);
        do_commit();
        do_out(2'd2);
        idle_cycles(20);
        rst_n = 1'b0;
        quiet_inputs();
        step();
        rst_n = 1'b1;
        idle_cycles(N + 3);
        for (int i = 0; i < N; i++) begin
            quiet_inputs();
            bus.eq_coeff_addr = AW'(i);
            step();
        end
        idle_cycles(2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", edge_n, W'(exp_q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
